// File: rtl/spi_fsm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_fsm_pkg
// Purpose  : Shared state encoding and address-byte field positions for the
//            SPI memory-frame controller.
// Revision : 1.0 - initial release
// ============================================================================
package spi_fsm_pkg;

  // Three-bit state codes for the frame sequencer
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_GET_ADDR    = 3'd1;
  localparam logic [2:0] ST_LATCH_ADDR  = 3'd2;
  localparam logic [2:0] ST_READ_LOAD   = 3'd3;
  localparam logic [2:0] ST_READ_SHIFT  = 3'd4;
  localparam logic [2:0] ST_WRITE_GET   = 3'd5;
  localparam logic [2:0] ST_WRITE_STORE = 3'd6;
  localparam logic [2:0] ST_DONE        = 3'd7;

  // Position of the read/write flag inside the address byte (1 = read)
  localparam int RW_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_GET_ADDR    = ST_GET_ADDR,
    S_LATCH_ADDR  = ST_LATCH_ADDR,
    S_READ_LOAD   = ST_READ_LOAD,
    S_READ_SHIFT  = ST_READ_SHIFT,
    S_WRITE_GET   = ST_WRITE_GET,
    S_WRITE_STORE = ST_WRITE_STORE,
    S_DONE        = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_fsm_if
// Purpose  : Bundle of conditioned SPI inputs and datapath strobes between
//            the front end / shift register and the frame controller.
//            master = stimulus side, slave = frame controller.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs_n;
  logic                  sclk_posedge;
  logic                  sclk_negedge;
  logic [DATA_WIDTH-1:0] sr_pout;
  logic                  addr_we;
  logic                  sr_we;
  logic                  dm_we;
  logic                  miso_buff_en;
  logic                  frame_err;

  modport master (
    output cs_n, sclk_posedge, sclk_negedge, sr_pout,
    input  addr_we, sr_we, dm_we, miso_buff_en, frame_err
  );

  modport slave (
    input  cs_n, sclk_posedge, sclk_negedge, sr_pout,
    output addr_we, sr_we, dm_we, miso_buff_en, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_fsm_bit_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_bit_counter
// Purpose  : Saturating bit counter with synchronous clear and count enable.
//            o_last flags that the next enabled increment reaches MAX, so
//            the controller can leave a phase on the very pulse that
//            completes it.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bit_counter #(
  parameter int MAX   = 8,
  parameter int WIDTH = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_last
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_last = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] r_cnt;

  // Count enabled edges; clear has priority and the value never passes MAX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/spi_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_fsm
// Purpose  : SPI memory-frame sequencer: address/RW byte followed by one
//            data byte read or written. Moore strobes for address latch,
//            shift-register load, data-memory write and MISO enable.
//            Optional sticky abort flag enabled by SPI_FSM_FRAME_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  spi_fsm_if.slave  bus
);
  import spi_fsm_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   w_cnt_clr;
  logic   w_cnt_en;
  logic   w_cnt_last;

  spi_bit_counter #(
    .MAX   (DATA_WIDTH),
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_last (w_cnt_last)
  );

  // State register; async reset drops every Moore output immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and counter control; chip-select deassertion beats any edge
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.cs_n) begin
          w_next    = S_GET_ADDR;
          w_cnt_clr = 1'b1;
        end
      end
      S_GET_ADDR: begin
        if (bus.cs_n) begin
          w_next    = S_IDLE;
          w_cnt_clr = 1'b1;
        end else if (bus.sclk_posedge) begin
          w_cnt_en = 1'b1;
          if (w_cnt_last) begin
            w_next = S_LATCH_ADDR;
          end
        end
      end
      S_LATCH_ADDR: begin
        // Shift register already holds the full address byte here
        w_cnt_clr = 1'b1;
        if (bus.cs_n) begin
          w_next = S_IDLE;
        end else if (bus.sr_pout[RW_BIT]) begin
          w_next = S_READ_LOAD;
        end else begin
          w_next = S_WRITE_GET;
        end
      end
      S_READ_LOAD: begin
        w_next = bus.cs_n ? S_IDLE : S_READ_SHIFT;
      end
      S_READ_SHIFT: begin
        if (bus.cs_n) begin
          w_next    = S_IDLE;
          w_cnt_clr = 1'b1;
        end else if (bus.sclk_negedge) begin
          w_cnt_en = 1'b1;
          if (w_cnt_last) begin
            w_next = S_DONE;
          end
        end
      end
      S_WRITE_GET: begin
        if (bus.cs_n) begin
          w_next    = S_IDLE;
          w_cnt_clr = 1'b1;
        end else if (bus.sclk_posedge) begin
          w_cnt_en = 1'b1;
          if (w_cnt_last) begin
            w_next = S_WRITE_STORE;
          end
        end
      end
      S_WRITE_STORE: begin
        w_next = bus.cs_n ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (bus.cs_n) begin
          w_next    = S_IDLE;
          w_cnt_clr = 1'b1;
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  assign bus.addr_we      = (r_state == S_LATCH_ADDR);
  assign bus.sr_we        = (r_state == S_READ_LOAD);
  assign bus.dm_we        = (r_state == S_WRITE_STORE);
  assign bus.miso_buff_en = (r_state == S_READ_SHIFT);

`ifdef SPI_FSM_FRAME_ERR_EN
  logic r_frame_err;
  logic w_abort;
  logic w_err_clr;

  assign w_abort   = bus.cs_n && ((r_state == S_GET_ADDR) ||
                                  (r_state == S_READ_SHIFT) ||
                                  (r_state == S_WRITE_GET));
  assign w_err_clr = (r_state == S_IDLE) && !bus.cs_n;

  // Sticky abort flag, cleared when the next frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
    end else if (w_abort) begin
      r_frame_err <= 1'b1;
    end else if (w_err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  assign bus.frame_err = r_frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_fsm
// Purpose  : Self-checking bench for spi_fsm. Each frame is a per-cycle
//            stimulus table; expected strobe timing is derived by scanning
//            that table with the frame rules (count edges, locate the
//            completing edge, place the one-cycle strobes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fsm;
  import spi_fsm_pkg::*;

  localparam int DW   = 8;
  localparam int MAXN = 160;
`ifdef SPI_FSM_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_fsm_if #(.DATA_WIDTH(DW)) bus();

  spi_fsm #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus table for one frame (cycle t drives the inputs sampled at edge t)
  bit         cs_a   [MAXN];
  bit         pos_a  [MAXN];
  bit         neg_a  [MAXN];
  logic [7:0] pout_a [MAXN];
  int         n_cyc;

  // Expected outputs observed just after edge t
  bit e_addr [MAXN];
  bit e_sr   [MAXN];
  bit e_dm   [MAXN];
  bit e_miso [MAXN];
  bit e_err  [MAXN];

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // Regular SCLK: posedge on odd cycles, negedge on even cycles, n_pairs of each
  task automatic build(input int n_pairs, input int len, input int gap,
                       input logic [7:0] b0, input logic [7:0] b1);
    n_cyc = len + gap;
    for (int t = 0; t < n_cyc; t++) begin
      cs_a[t]   = (t >= len);
      pos_a[t]  = ((t % 2) == 1) && (t < 2 * n_pairs + 1);
      neg_a[t]  = ((t % 2) == 0) && (t > 0) && (t <= 2 * n_pairs);
      pout_a[t] = (t <= 16) ? b0 : b1;
    end
  endtask

  task automatic build_random();
    int len;
    int gap;
    len   = int'($urandom_range(5, 60));
    gap   = int'($urandom_range(1, 4));
    n_cyc = len + gap;
    for (int t = 0; t < n_cyc; t++) begin
      cs_a[t]   = (t >= len);
      pos_a[t]  = bit'($urandom_range(0, 1));
      neg_a[t]  = bit'($urandom_range(0, 1));
      pout_a[t] = 8'($urandom);
    end
  endtask

  // Derive expected strobes from the stimulus table (frame starts in IDLE)
  task automatic model_frame();
    int c;
    int ta;
    int ab;
    ta = -1;
    ab = -1;
    for (int t = 0; t < n_cyc; t++) begin
      e_addr[t] = 1'b0; e_sr[t] = 1'b0; e_dm[t] = 1'b0;
      e_miso[t] = 1'b0; e_err[t] = 1'b0;
    end
    // Edge 0 starts the frame; address edges count from edge 1
    c = 0;
    for (int e = 1; e < n_cyc; e++) begin
      if (cs_a[e]) begin ab = e; break; end
      if (pos_a[e]) begin
        c++;
        if (c == DW) begin ta = e; break; end
      end
    end
    if (ta >= 0) begin
      e_addr[ta] = 1'b1;
      if (!cs_a[ta + 1]) begin
        if (pout_a[ta + 1][0]) begin
          e_sr[ta + 1] = 1'b1;
          if (!cs_a[ta + 2]) begin
            e_miso[ta + 2] = 1'b1;
            c = 0;
            for (int e = ta + 3; e < n_cyc; e++) begin
              if (cs_a[e]) begin ab = e; break; end
              if (neg_a[e]) c++;
              if (c == DW) break;
              e_miso[e] = 1'b1;
            end
          end
        end else begin
          c = 0;
          for (int e = ta + 2; e < n_cyc; e++) begin
            if (cs_a[e]) begin ab = e; break; end
            if (pos_a[e]) begin
              c++;
              if (c == DW) begin e_dm[e] = 1'b1; break; end
            end
          end
        end
      end
    end
    for (int t = 0; t < n_cyc; t++) begin
      e_err[t] = ERR_EN && (ab >= 0) && (t >= ab);
    end
  endtask

  task automatic run_frame(input string tag, input int from, input int upto);
    for (int t = from; t < upto; t++) begin
      bus.cs_n         = cs_a[t];
      bus.sclk_posedge = pos_a[t];
      bus.sclk_negedge = neg_a[t];
      bus.sr_pout      = pout_a[t];
      @(posedge clk);
      #1;
      check({tag, ".addr_we"},      t, 32'(bus.addr_we),      32'(e_addr[t]));
      check({tag, ".sr_we"},        t, 32'(bus.sr_we),        32'(e_sr[t]));
      check({tag, ".dm_we"},        t, 32'(bus.dm_we),        32'(e_dm[t]));
      check({tag, ".miso_buff_en"}, t, 32'(bus.miso_buff_en), 32'(e_miso[t]));
      check({tag, ".frame_err"},    t, 32'(bus.frame_err),    32'(e_err[t]));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".addr_we"},      0, 32'(bus.addr_we),      32'd0);
    check({tag, ".sr_we"},        0, 32'(bus.sr_we),        32'd0);
    check({tag, ".dm_we"},        0, 32'(bus.dm_we),        32'd0);
    check({tag, ".miso_buff_en"}, 0, 32'(bus.miso_buff_en), 32'd0);
    check({tag, ".frame_err"},    0, 32'(bus.frame_err),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.cs_n         = 1'b1;
    bus.sclk_posedge = 1'b0;
    bus.sclk_negedge = 1'b0;
    bus.sr_pout      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset.state", 0, 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write frame: address 0x2A with W flag, data 0xC3
    build(16, 35, 2, 8'h54, 8'hC3);
    model_frame();
    run_frame("write", 0, n_cyc);

    // Read frame: address 0x2A with R flag
    build(16, 35, 2, 8'h55, 8'hAA);
    model_frame();
    run_frame("read", 0, n_cyc);

    // Abort after five address edges
    build(16, 11, 2, 8'h55, 8'h00);
    model_frame();
    run_frame("abort", 0, n_cyc);
    check("abort.state", 0, 32'(dut.r_state), 32'(ST_IDLE));

    // Chip-select rises together with the eighth address posedge
    build(16, 15, 2, 8'h55, 8'h00);
    model_frame();
    run_frame("coincide", 0, n_cyc);
    check("coincide.state", 0, 32'(dut.r_state), 32'(ST_IDLE));

    // Back-to-back: read, one idle clock, then write
    build(16, 35, 1, 8'h55, 8'h3C);
    model_frame();
    run_frame("b2b_read", 0, n_cyc);
    build(16, 35, 2, 8'h54, 8'h96);
    model_frame();
    run_frame("b2b_write", 0, 1);
    check("b2b.bit_cnt", 0, 32'(dut.u_cnt.r_cnt), 32'd0);
    run_frame("b2b_write", 1, n_cyc);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      build_random();
      model_frame();
      run_frame("random", 0, n_cyc);
    end

    // Asynchronous reset while shifting out read data
    build(16, 35, 2, 8'h55, 8'h00);
    model_frame();
    run_frame("pre_reset", 0, 22);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    bus.cs_n         = 1'b1;
    bus.sclk_posedge = 1'b0;
    bus.sclk_negedge = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.state", 0, 32'(dut.r_state), 32'(ST_IDLE));
    check_quiet("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
- Transaction controller sitting directly downstream of the shift register.
- Consumes the conditioned chip-select, the conditioned serial-clock edge pulses and the shift register's parallel output.
- Sequences one SPI memory frame: address/RW byte, then either a read or a write of one data byte.
- Drives the shift register's parallel-load strobe, the address-latch enable, the data-memory write enable and the MISO tri-state buffer enable.

Parameters:
- DATA_WIDTH, 8: bits per frame phase; equals shift register width.
- CNT_WIDTH, 4: bit-counter width; must hold DATA_WIDTH (≥ clog2(DATA_WIDTH+1)).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- cs_n  input  1  conditioned chip select, active low.
- sclk_posedge  input  1  one-clk pulse on conditioned SCLK rising edge.
- sclk_negedge  input  1  one-clk pulse on conditioned SCLK falling edge.
- sr_pout  input  DATA_WIDTH  shift register parallel output; bit 0 = R/W flag in the address byte (1 = read).
- addr_we  output  1  address latch enable, one-clk pulse.
- sr_we  output  1  shift register parallel-load enable, one-clk pulse.
- dm_we  output  1  data memory write enable, one-clk pulse.
- miso_buff_en  output  1  MISO tri-state enable.
- frame_err  output  1  sticky abort flag (see Optional Feature).

Behaviour:
- Outputs are Moore, decoded from the state register. On reset, all outputs = 0, state = IDLE, bit_cnt = 0.
- States: IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_STORE, DONE.
- IDLE: cs_n = 0 → GET_ADDR, bit_cnt ← 0.
- GET_ADDR: each sclk_posedge increments bit_cnt. On the pulse that makes bit_cnt = DATA_WIDTH → LATCH_ADDR.
- LATCH_ADDR (1 clk): addr_we = 1. bit_cnt ← 0. sr_pout[0] = 1 → READ_LOAD, else → WRITE_GET. sr_pout is complete here because the shift register updates in the same clk as the 8th edge.
- READ_LOAD (1 clk): sr_we = 1 → READ_SHIFT.
- READ_SHIFT: miso_buff_en = 1. Each sclk_negedge increments bit_cnt. On the pulse that makes bit_cnt = DATA_WIDTH → DONE.
- WRITE_GET: each sclk_posedge increments bit_cnt. At DATA_WIDTH → WRITE_STORE.
- WRITE_STORE (1 clk): dm_we = 1 → DONE.
- DONE: all outputs 0. Extra SCLK edges are ignored. cs_n = 1 → IDLE.
- cs_n = 1 in any state other than IDLE → IDLE next clk, bit_cnt ← 0.
  - cs_n rising coincident with an SCLK pulse: chip-select wins; the pulse is ignored.
  - cs_n rising in LATCH_ADDR, READ_LOAD or WRITE_STORE: the strobe already asserted that cycle stands; no further strobes follow.
- Edge pulses in IDLE, LATCH_ADDR, READ_LOAD and WRITE_STORE do not count.
- sclk_posedge and sclk_negedge both high in one clk: only the edge relevant to the current state counts.
- bit_cnt never exceeds DATA_WIDTH. Each of addr_we, sr_we and dm_we is exactly one clk wide, at most once per frame.
- Async reset mid-frame returns to IDLE immediately. Outputs drop without waiting for clk.

Optional Feature:
- Macro: SPI_FSM_FRAME_ERR_EN.
- With the macro: frame_err is set when cs_n rises in GET_ADDR, READ_SHIFT or WRITE_GET (frame aborted). It clears on reset or on the next cs_n falling in IDLE. Reset value 0.
- Without the macro: frame_err is tied to 0 and no extra flops are inferred.

Decomposition:
- Shared package holds the state encoding constants (3-bit localparams for the eight states) and the R/W bit index.
- One sub-module, spi_bit_counter: saturating up-counter with clear, enable and terminal-count output. The FSM instantiates it once.

Test Plan:
- Reset check: assert reset mid-READ_SHIFT → all outputs 0 in the same cycle; state IDLE after release.
- Write frame: cs_n = 0; 8 posedges with sr_pout = 8'h54 (addr 0x2A, W), then 8 posedges with sr_pout = 8'hC3 → one addr_we pulse after the 8th address edge; one dm_we pulse after the 16th edge; miso_buff_en stays 0.
- Read frame: address byte 8'h55 (addr 0x2A, R) → addr_we, then sr_we on the next clk; miso_buff_en high for exactly 8 negedges, then 0; dm_we never asserted.
- Abort: cs_n rises after 5 address edges → IDLE next clk; no strobes; frame_err = 1 with SPI_FSM_FRAME_ERR_EN defined, 0 without.
- Coincidence: cs_n rises in the same clk as the 8th address posedge → no addr_we; state IDLE.
- Back-to-back: a read frame, cs_n high 1 clk, then a write frame → both frames complete; bit_cnt restarts at 0 for the second frame.
